// File: rtl/sfp_norm_ctrl_pkg.sv
// sfp_norm_ctrl shared types: FSM state enum, pipeline delays,
// and the row-count saturation helper.
package sfp_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ACC,
    DRAIN,
    SYNC,
    DIV,
    FLUSH,
    DONE
  } state_e;

  // last acc + sum_q register + FIFO write
  localparam int DRAIN_CYCLES = 3;
  // psum read data arrives one cycle after psum_rd
  localparam int PSUM_RD_LAT = 1;
  // sfp_row result is written one cycle after div
  localparam int DIV_TO_WR = 1;
  localparam int WR_LAT = PSUM_RD_LAT + DIV_TO_WR;

  function automatic int unsigned sat_rows(
    input int unsigned n,
    input int unsigned lim
  );
    return (n > lim) ? lim : n;
  endfunction

endpackage

// File: rtl/sfp_norm_ctrl_if.sv
// Command bus between the instruction decoder and sfp_norm_ctrl.
// master: start/num_rows out, busy/done/err in; slave: the reverse.
interface sfp_norm_ctrl_if #(
  parameter int ADDR_W = 4
);

  logic              start;
  logic [ADDR_W:0]   num_rows;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output start,
    output num_rows,
    input  busy,
    input  done,
    input  err
  );

  modport slave (
    input  start,
    input  num_rows,
    output busy,
    output done,
    output err
  );

endinterface

// File: rtl/sfp_norm_ctrl_seq.sv
// sfp_row_seq: row counter / address generator shared by both passes.
// Ports: clk, reset, start+count (load), active, addr, last (final row).
module sfp_row_seq #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   count,
  output logic              active,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic [ADDR_W:0] cnt_q;

  assign last = active &&
    ({1'b0, addr} == cnt_q - 1'b1);

  always_ff @(posedge clk) begin
    if (reset) begin
      active <= 1'b0;
      addr   <= '0;
      cnt_q  <= '0;
    end else if (start && count != '0) begin
      active <= 1'b1;
      addr   <= '0;
      cnt_q  <= count;
    end else if (last) begin
      // park address at 0 so idle outputs read 0
      active <= 1'b0;
      addr   <= '0;
    end else if (active) begin
      addr   <= addr + 1'b1;
    end
  end

endmodule

// File: rtl/sfp_norm_ctrl.sv
// sfp_norm_ctrl: two-pass (acc, sync, div) sequencer for one sfp_row core.
// Ports: clk, reset, cmd (start/num_rows/busy/done/err), psum_rd/psum_addr,
//   acc, div, fifo_ext_rd, sum_ready_out/in, sfp_wr/sfp_addr.
// Option: SFP_CTRL_TIMEOUT_EN bounds the SYNC wait to TIMEOUT cycles.
module sfp_norm_ctrl
  import sfp_ctrl_pkg::*;
#(
  parameter int ROWS_MAX = 16,
  parameter int ADDR_W   = 4,
  parameter int TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              reset,
  sfp_norm_ctrl_if.slave    cmd,
  output logic              psum_rd,
  output logic [ADDR_W-1:0] psum_addr,
  output logic              acc,
  output logic              div,
  output logic              fifo_ext_rd,
  output logic              sum_ready_out,
  input  logic              sum_ready_in,
  output logic              sfp_wr,
  output logic [ADDR_W-1:0] sfp_addr
);

  localparam int NW = ADDR_W + 1;
  localparam int CNT_W =
    $clog2(TIMEOUT + DRAIN_CYCLES + 2);

  state_e state, state_n;

  logic busy_q, busy_n;
  logic done_q, done_n;
  logic sro_q, sro_n;
  logic err_q, err_n;

  logic [CNT_W-1:0] cnt, cnt_n;
  logic [NW-1:0] n_q, n_n, n_sat;
  logic [NW-1:0] seq_count;
  logic seq_start, seq_last;
  logic [ADDR_W-1:0] row_q;

  assign n_sat = NW'(sat_rows(
    32'(cmd.num_rows), 32'(ROWS_MAX)));

  sfp_row_seq #(
    .ADDR_W (ADDR_W)
  ) u_seq (
    .clk    (clk),
    .reset  (reset),
    .start  (seq_start),
    .count  (seq_count),
    .active (psum_rd),
    .addr   (psum_addr),
    .last   (seq_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      sro_q       <= 1'b0;
      err_q       <= 1'b0;
      cnt         <= '0;
      n_q         <= '0;
      acc         <= 1'b0;
      div         <= 1'b0;
      fifo_ext_rd <= 1'b0;
      row_q       <= '0;
      sfp_wr      <= 1'b0;
      sfp_addr    <= '0;
    end else begin
      state       <= state_n;
      busy_q      <= busy_n;
      done_q      <= done_n;
      sro_q       <= sro_n;
      err_q       <= err_n;
      cnt         <= cnt_n;
      n_q         <= n_n;
      // read data lands one cycle after psum_rd
      acc         <= psum_rd && (state == ACC);
      div         <= psum_rd && (state == DIV);
      fifo_ext_rd <= psum_rd && (state == DIV);
      row_q       <= psum_addr;
      sfp_wr      <= div;
      sfp_addr    <= div ? row_q : '0;
    end
  end

  always_comb begin
    state_n   = state;
    busy_n    = busy_q;
    done_n    = 1'b0;
    sro_n     = sro_q;
    err_n     = err_q;
    cnt_n     = cnt;
    n_n       = n_q;
    seq_start = 1'b0;
    seq_count = n_q;
    unique case (state)
      IDLE: begin
        if (cmd.start) begin
          busy_n = 1'b1;
          err_n  = 1'b0;
          n_n    = n_sat;
          cnt_n  = '0;
          if (n_sat == '0) begin
            state_n = DONE;
            done_n  = 1'b1;
          end else begin
            state_n   = ACC;
            seq_start = 1'b1;
            seq_count = n_sat;
          end
        end
      end
      ACC: begin
        // leave after the final acc strobe
        if (acc && !psum_rd) begin
          state_n = DRAIN;
          cnt_n   = '0;
        end
      end
      DRAIN: begin
        if (cnt == CNT_W'(DRAIN_CYCLES - 1)) begin
          state_n = SYNC;
          sro_n   = 1'b1;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      SYNC: begin
        if (sro_q && sum_ready_in) begin
          state_n   = DIV;
          sro_n     = 1'b0;
          seq_start = 1'b1;
        end
`ifdef SFP_CTRL_TIMEOUT_EN
        else if (cnt == CNT_W'(TIMEOUT)) begin
          state_n = DONE;
          done_n  = 1'b1;
          err_n   = 1'b1;
          sro_n   = 1'b0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
`endif
      end
      DIV: begin
        if (seq_last) begin
          state_n = FLUSH;
          cnt_n   = '0;
        end
      end
      FLUSH: begin
        // covers div and sfp_wr trailing the last read
        if (cnt == CNT_W'(WR_LAT - 1)) begin
          state_n = DONE;
          done_n  = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DONE: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign cmd.busy      = busy_q;
  assign cmd.done      = done_q;
  assign sum_ready_out = sro_q;

`ifdef SFP_CTRL_TIMEOUT_EN
  assign cmd.err = err_q;
`else
  assign cmd.err = 1'b0;
`endif

endmodule

// File: tb/tb_sfp_norm_ctrl.sv
// Self-checking bench for sfp_norm_ctrl: directed plus random operations
// compared per cycle against a row-window model of the two passes.
module tb_sfp_norm_ctrl;

  localparam int AW  = 4;
  localparam int TMO = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sfp_norm_ctrl_if #(.ADDR_W(AW)) cmd_a ();
  sfp_norm_ctrl_if #(.ADDR_W(AW)) cmd_b ();

  logic prd_a, acc_a, div_a, fx_a;
  logic sro_a, sri_a, wr_a;
  logic [AW-1:0] pa_a, wa_a;
  logic prd_b, acc_b, div_b, fx_b;
  logic sro_b, sri_b, wr_b;
  logic [AW-1:0] pa_b, wa_b;

  int   mode;
  logic peer;

  assign sri_a = (mode == 0) ? sro_a :
                 (mode == 1) ? peer : sro_b;
  assign sri_b = (mode == 2) ? sro_a : 1'b0;

  sfp_norm_ctrl #(
    .ROWS_MAX (16),
    .ADDR_W   (AW),
    .TIMEOUT  (TMO)
  ) dut_a (
    .clk           (clk),
    .reset         (reset),
    .cmd           (cmd_a),
    .psum_rd       (prd_a),
    .psum_addr     (pa_a),
    .acc           (acc_a),
    .div           (div_a),
    .fifo_ext_rd   (fx_a),
    .sum_ready_out (sro_a),
    .sum_ready_in  (sri_a),
    .sfp_wr        (wr_a),
    .sfp_addr      (wa_a)
  );

  sfp_norm_ctrl #(
    .ROWS_MAX (16),
    .ADDR_W   (AW),
    .TIMEOUT  (TMO)
  ) dut_b (
    .clk           (clk),
    .reset         (reset),
    .cmd           (cmd_b),
    .psum_rd       (prd_b),
    .psum_addr     (pa_b),
    .acc           (acc_b),
    .div           (div_b),
    .fifo_ext_rd   (fx_b),
    .sum_ready_out (sro_b),
    .sum_ready_in  (sri_b),
    .sfp_wr        (wr_b),
    .sfp_addr      (wa_b)
  );

  int checks = 0;
  int errors = 0;
  int cur_k  = 0;

  function automatic logic [16:0] obs_a();
    return {cmd_a.busy, cmd_a.done, cmd_a.err,
            prd_a, pa_a, acc_a, div_a, fx_a,
            sro_a, wr_a, wa_a};
  endfunction

  function automatic logic [16:0] obs_b();
    return {cmd_b.busy, cmd_b.done, cmd_b.err,
            prd_b, pa_b, acc_b, div_b, fx_b,
            sro_b, wr_b, wa_b};
  endfunction

  // Reference timeline, offsets k from the cycle start is high:
  // reads 1..n, acc +1, 3 drain cycles, SYNC from n+5 until
  // the peer is also ready (cycle h), reads h+1..h+n,
  // div +1, write +2, done at h+n+3.
  function automatic int eff_n(input int n_req);
    return (n_req > 16) ? 16 : n_req;
  endfunction

  function automatic bit tmo_of(input int n_req, input int hp);
`ifdef SFP_CTRL_TIMEOUT_EN
    int n = eff_n(n_req);
    int y = n + 5;
    int h = (hp > y) ? hp : y;
    return (n > 0) && (h - y > TMO);
`else
    return (n_req < 0) && (hp < 0);
`endif
  endfunction

  function automatic int done_at(input int n_req, input int hp);
    int n = eff_n(n_req);
    int y = n + 5;
    int h = (hp > y) ? hp : y;
    if (n == 0) return 1;
    if (tmo_of(n_req, hp)) return y + TMO + 1;
    return h + n + 3;
  endfunction

  function automatic logic [16:0] model(
    input int k, input int n_req, input int hp
  );
    int n = eff_n(n_req);
    int y = n + 5;
    int h = (hp > y) ? hp : y;
    int d = done_at(n_req, hp);
    bit t = tmo_of(n_req, hp);
    logic b, dn, er, pr, ac, dv, sr, wr;
    logic [3:0] pa, wa;
    b = (k >= 1) && (k <= d);
    dn = (k == d);
    er = t && (k >= d);
    pr = 0; ac = 0; dv = 0; sr = 0; wr = 0;
    pa = '0; wa = '0;
    if (n > 0) begin
      if (k >= 1 && k <= n) begin
        pr = 1; pa = 4'(k - 1);
      end
      ac = (k >= 2) && (k <= n + 1);
      sr = (k >= y) && (k <= (t ? d - 1 : h));
      if (!t) begin
        if (k >= h + 1 && k <= h + n) begin
          pr = 1; pa = 4'(k - h - 1);
        end
        dv = (k >= h + 2) && (k <= h + n + 1);
        if (k >= h + 3 && k <= h + n + 2) begin
          wr = 1; wa = 4'(k - h - 3);
        end
      end
    end
    return {b, dn, er, pr, pa, ac, dv, dv, sr, wr, wa};
  endfunction

  task automatic chk(
    input string tag,
    input logic [16:0] o,
    input logic [16:0] e
  );
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s k=%0d obs=%h exp=%h",
             tag, cur_k, o, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(
    input  int n_req,
    input  int m,
    input  int e,
    input  int s1,
    input  int s2,
    input  int abort_k,
    output int done_k
  );
    int hp;
    int d;
    hp = (m == 1) ? e : 0;
    d = done_at(n_req, hp);
    done_k = -1;
    mode = m;
    peer = 1'b0;
    cur_k = 0;
    cmd_a.start = 1'b1;
    cmd_a.num_rows = 5'(n_req);
    for (int k = 1; k <= d + 3; k++) begin
      tick();
      cur_k = k;
      cmd_a.start = (k == s1) || (k == s2);
      cmd_a.num_rows = 5'($urandom_range(0, 31));
      if (m == 1) peer = (k >= e);
      if (cmd_a.done) done_k = k;
      chk("op", obs_a(), model(k, n_req, hp));
      if (k == abort_k) begin
        cmd_a.start = 1'b0;
        reset = 1'b1;
        tick();
        cur_k = k + 1;
        chk("rst_zero", obs_a(), '0);
        reset = 1'b0;
        for (int j = 0; j < 3; j++) begin
          tick();
          chk("post_rst", obs_a(), '0);
        end
        break;
      end
    end
    cmd_a.start = 1'b0;
    peer = 1'b0;
  endtask

  initial begin
    int dk;
    int n, m, e, d, s1, s2, y;
    reset = 1'b1;
    mode = 0;
    peer = 1'b0;
    cmd_a.start = 1'b0;
    cmd_a.num_rows = '0;
    cmd_b.start = 1'b0;
    cmd_b.num_rows = '0;
    tick();
    tick();
    chk("reset_a", obs_a(), '0);
    chk("reset_b", obs_b(), '0);
    reset = 1'b0;
    tick();
    chk("idle_a", obs_a(), '0);

    // loopback, 4 rows
    run_op(4, 0, 0, 0, 0, 0, dk);
    chk("n4_done", 17'(dk), 17'(16));

    // full pass latency with the peer already ready
    run_op(16, 0, 0, 0, 0, 0, dk);
    chk("lat16", 17'(dk), 17'(40));

    // peer becomes ready well after this core
`ifdef SFP_CTRL_TIMEOUT_EN
    run_op(16, 1, 21 + 5, 0, 0, 0, dk);
`else
    run_op(16, 1, 21 + 10, 0, 0, 0, dk);
    chk("late_done", 17'(dk), 17'(50));
`endif

    // empty and oversize requests
    run_op(0, 0, 0, 0, 0, 0, dk);
    chk("n0_done", 17'(dk), 17'(1));
    run_op(20, 0, 0, 0, 0, 0, dk);

    // early peer, stray starts in ACC and DIV
    run_op(8, 1, 2, 3, 16, 0, dk);

    // reset in the middle of DIV, then a clean run
    run_op(8, 0, 0, 0, 0, 17, dk);
    chk("abort_nodone", 17'(dk), 17'h1ffff);
    run_op(6, 0, 0, 0, 0, 0, dk);

    // two cores cross-coupled, second starts 5 cycles late
    n = 6;
    y = n + 5;
    d = done_at(n, y + 5);
    mode = 2;
    cur_k = 0;
    cmd_a.start = 1'b1;
    cmd_a.num_rows = 5'(n);
    for (int k = 1; k <= d + 3; k++) begin
      tick();
      cur_k = k;
      cmd_a.start = 1'b0;
      cmd_b.start = (k == 5);
      cmd_b.num_rows = 5'(n);
      chk("xc_a", obs_a(), model(k, n, y + 5));
      chk("xc_b", obs_b(), model(k - 5, n, 0));
    end
    cmd_b.start = 1'b0;
    mode = 0;

`ifdef SFP_CTRL_TIMEOUT_EN
    // peer never answers; err then cleared by next start
    run_op(5, 1, 1000, 0, 0, 0, dk);
    chk("tmo_done", 17'(dk), 17'(10 + TMO + 1));
    run_op(3, 0, 0, 0, 0, 0, dk);
`endif

    // random operations
    for (int i = 0; i < 14; i++) begin
      n = int'($urandom_range(0, 20));
      m = int'($urandom_range(0, 1));
      e = int'($urandom_range(1, eff_n(n) + 17));
      d = done_at(n, (m == 1) ? e : 0);
      s1 = int'($urandom_range(1, d));
      s2 = int'($urandom_range(0, d));
      run_op(n, m, e, s1, s2, 0, dk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
